// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-pipeline definitions: FSM state encoding, reset/NOP defaults
// and the address helper used by the fetch unit.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] INSTR_BYTES       = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and the
// fetch-to-decode handshake. master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        d_ready_i;
   logic        f_valid_o;
   logic [31:0] f_instruction_o;
   logic [31:0] f_pc_o;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      input  redirect_i,
      input  redirect_pc_i,
      input  d_ready_i,
      output f_valid_o,
      output f_instruction_o,
      output f_pc_o
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_rvalid_i,
      output imem_rdata_i,
      output redirect_i,
      output redirect_pc_i,
      output d_ready_i,
      input  f_valid_o,
      input  f_instruction_o,
      input  f_pc_o
   );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding instruction memory read, a single
// held instruction toward decode, and redirect with highest priority.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FETCH | issue read at pc (suppressed while redirect is asserted)
// S_WAIT  | read outstanding; drop set means the returning data is stale
// S_HOLD  | instruction presented to decode, waiting for d_ready_i
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input logic                      clk_i,
   input logic                      rst_i,
   instruction_fetch_unit_if.master bus
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         drop;
   logic         f_valid_q;
   logic [31:0]  f_instruction_q;
   logic [31:0]  f_pc_q;

   // The request is the one combinational output: it must vanish in the same
   // cycle a redirect arrives, so it cannot wait for a register stage.
   assign bus.imem_req_o      = (state == S_FETCH) && !bus.redirect_i && !rst_i;
   assign bus.imem_addr_o     = pc;
   assign bus.f_valid_o       = f_valid_q;
   assign bus.f_instruction_o = f_instruction_q;
   assign bus.f_pc_o          = f_pc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= S_FETCH;
         pc              <= word_align(RESET_PC);
         drop            <= 1'b0;
         f_valid_q       <= 1'b0;
         f_instruction_q <= NOP_INSTR;
         f_pc_q          <= 32'h0000_0000;
      end else if (bus.redirect_i) begin
         pc              <= word_align(bus.redirect_pc_i);
         f_valid_q       <= 1'b0;
         f_instruction_q <= NOP_INSTR;
         case (state)
            S_WAIT: begin
               // An unreturned read must still be drained before refetching.
               if (bus.imem_rvalid_i) begin
                  drop  <= 1'b0;
                  state <= S_FETCH;
               end else begin
                  drop  <= 1'b1;
               end
            end
            default: begin
               drop  <= 1'b0;
               state <= S_FETCH;
            end
         endcase
      end else begin
         case (state)
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.imem_rvalid_i) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= S_FETCH;
                  end else begin
                     f_instruction_q <= bus.imem_rdata_i;
                     f_pc_q          <= pc;
                     f_valid_q       <= 1'b1;
                     pc              <= pc + INSTR_BYTES;
                     state           <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (bus.d_ready_i) begin
                  f_valid_q       <= 1'b0;
                  f_instruction_q <= NOP_INSTR;
                  state           <= S_FETCH;
               end
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: drives the memory/decode side
// cycle by cycle and compares against hand-computed values.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
      #1;
      check_val({tag, " req"}, {31'd0, bus.imem_req_o}, {31'd0, exp_req});
      if (exp_req) check_val({tag, " addr"}, bus.imem_addr_o, exp_addr);
   endtask

   task automatic check_out(input string tag, input logic exp_valid, input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc);
      check_val({tag, " f_valid"}, {31'd0, bus.f_valid_o}, {31'd0, exp_valid});
      check_val({tag, " f_instr"}, bus.f_instruction_o, exp_instr);
      check_val({tag, " f_pc"}, bus.f_pc_o, exp_pc);
   endtask

   // Starts in FETCH; ends one cycle after the data beat, i.e. in HOLD.
   task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input int lat);
      bus.imem_rvalid_i = 1'b0;
      bus.redirect_i    = 1'b0;
      check_req({tag, " issue"}, 1'b1, addr);
      cyc();
      for (int i = 1; i < lat; i++) begin
         check_req({tag, " wait"}, 1'b0, 32'h0);
         cyc();
      end
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = data;
      check_req({tag, " beat"}, 1'b0, 32'h0);
      cyc();
      bus.imem_rvalid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      bus.d_ready_i     = 1'b0;
      rst_i             = 1'b1;
      cyc();
      cyc();
      check_req("reset", 1'b0, 32'h0);
      check_out("reset", 1'b0, NOP, 32'h0);
      rst_i = 1'b0;

      // basic fetch at 1-cycle latency, decode ready
      bus.d_ready_i = 1'b1;
      do_fetch("t1", 32'h0, 32'h0050_0093, 1);
      check_out("t1 hold", 1'b1, 32'h0050_0093, 32'h0);
      cyc();
      check_out("t1 accept", 1'b0, NOP, 32'h0);

      // decode stalls 5 cycles; stray rvalid in HOLD is ignored
      bus.d_ready_i = 1'b0;
      do_fetch("t2", 32'h4, 32'h00A0_0113, 1);
      for (int i = 0; i < 5; i++) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = 32'hBAD0_BAD0;
         check_req("t2 stall", 1'b0, 32'h0);
         cyc();
         check_out("t2 stall", 1'b1, 32'h00A0_0113, 32'h4);
      end
      bus.imem_rvalid_i = 1'b0;
      bus.d_ready_i     = 1'b1;
      cyc();
      check_out("t2 release", 1'b0, NOP, 32'h4);

      // redirect while waiting, data returns two cycles later
      check_req("t3 issue", 1'b1, 32'h8);
      cyc();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0000_0103;
      check_req("t3 redir", 1'b0, 32'h0);
      cyc();
      bus.redirect_i = 1'b0;
      cyc();
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h1111_1111;
      cyc();
      bus.imem_rvalid_i = 1'b0;
      check_out("t3 drop", 1'b0, NOP, 32'h4);
      check_req("t3 refetch", 1'b1, 32'h0000_0100);

      // redirect coincident with the data beat
      cyc();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0000_0200;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'h2222_2222;
      cyc();
      bus.redirect_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      check_out("t4 drop", 1'b0, NOP, 32'h4);
      check_req("t4 refetch", 1'b1, 32'h0000_0200);

      // redirect in FETCH suppresses req; unaligned target; pc wrap
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFF;
      check_req("t5 redir", 1'b0, 32'h0);
      cyc();
      bus.redirect_i = 1'b0;
      do_fetch("t5", 32'hFFFF_FFFC, 32'h3333_3333, 2);
      check_out("t5 hold", 1'b1, 32'h3333_3333, 32'hFFFF_FFFC);
      cyc();

      // redirect in HOLD squashes despite d_ready
      do_fetch("t6", 32'h0, 32'hDEAD_BEEF, 1);
      check_out("t6 hold", 1'b1, 32'hDEAD_BEEF, 32'h0);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h0000_0040;
      cyc();
      bus.redirect_i = 1'b0;
      check_out("t6 squash", 1'b0, NOP, 32'h0);
      check_req("t6 refetch", 1'b1, 32'h0000_0040);

      // reset mid-WAIT, late rvalid after release is ignored
      cyc();
      rst_i = 1'b1;
      cyc();
      check_req("t7 in reset", 1'b0, 32'h0);
      rst_i             = 1'b0;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = 32'hBAD0_0001;
      check_req("t7 first", 1'b1, 32'h0);
      cyc();
      check_out("t7 late", 1'b0, NOP, 32'h0);
      bus.imem_rdata_i = 32'h0000_0777;
      cyc();
      bus.imem_rvalid_i = 1'b0;
      check_out("t7 fetch", 1'b1, 32'h0000_0777, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
